// File: rtl/ternary_pkg.sv
// Shared trit encodings, FSM state type and per-trit helpers for the
// balanced-ternary datapath.
package ternary_pkg;

  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_POS  = 2'b01;
  localparam logic [1:0] T_NEG  = 2'b10;
  localparam logic [1:0] T_BAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The illegal code is passed through unchanged so it is still flagged downstream.
  function automatic logic [1:0] trit_neg(input logic [1:0] t);
    case (t)
      T_POS:   return T_NEG;
      T_NEG:   return T_POS;
      default: return t;
    endcase
  endfunction

  // 3-bit two's complement value of a trit; the illegal code reads as zero.
  function automatic logic [2:0] trit_val(input logic [1:0] t);
    case (t)
      T_POS:   return 3'b001;
      T_NEG:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ternary_trit_full_add.sv
// Single balanced-ternary full adder: s + 3*cout = a + b + cin, plus an
// illegal-code detect on the two operand trits.
module ternary_trit_full_add
  import ternary_pkg::*;
(
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic [1:0] cin_i,
  output logic [1:0] s_o,
  output logic [1:0] cout_o,
  output logic       bad_o
);

  logic [2:0] tot;

  assign tot   = trit_val(a_i) + trit_val(b_i) + trit_val(cin_i);
  assign bad_o = (a_i == T_BAD) || (b_i == T_BAD);

  // tot is two's complement in [-3, 3]
  always_comb begin
    s_o    = T_ZERO;
    cout_o = T_ZERO;
    case (tot)
      3'b101: begin s_o = T_ZERO; cout_o = T_NEG;  end
      3'b110: begin s_o = T_POS;  cout_o = T_NEG;  end
      3'b111: begin s_o = T_NEG;  cout_o = T_ZERO; end
      3'b001: begin s_o = T_POS;  cout_o = T_ZERO; end
      3'b010: begin s_o = T_NEG;  cout_o = T_POS;  end
      3'b011: begin s_o = T_ZERO; cout_o = T_POS;  end
      default: begin s_o = T_ZERO; cout_o = T_ZERO; end
    endcase
  end

endmodule

// File: rtl/ternary_serial_addsub.sv
// Multi-cycle balanced-ternary adder/subtractor resolving TRITS_PER_CYCLE
// trits per clock, with valid/ready handshakes on both sides.
module ternary_serial_addsub
  import ternary_pkg::*;
#(
  parameter int N_TRITS         = 8,
  parameter int TRITS_PER_CYCLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*N_TRITS-1:0]   a,
  input  logic [2*N_TRITS-1:0]   b,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*N_TRITS-1:0]   sum,
  output logic [1:0]             carry_out,
  output logic                   illegal
);

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high; valid never waits on ready, and a held result stays stable.

  localparam int W  = 2 * N_TRITS;
  localparam int SW = 2 * TRITS_PER_CYCLE;
  localparam int NC = N_TRITS / TRITS_PER_CYCLE;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NC - 1);

  if ((TRITS_PER_CYCLE < 1) || (N_TRITS % TRITS_PER_CYCLE != 0)) begin : g_bad_cfg
    $error("TRITS_PER_CYCLE must be >= 1 and divide N_TRITS");
  end

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, acc_q, sum_q;
  logic [1:0]      carry_q, carry_out_q;
  logic            bad_q, illegal_q, out_valid_q;
  logic [CW-1:0]   cnt_q;

  logic [W-1:0]    b_neg;
  logic [SW-1:0]   step_sum;
  logic [TRITS_PER_CYCLE-1:0] step_bad_v;
  logic [1:0]      chain [TRITS_PER_CYCLE+1];
  logic [W+SW-1:0] acc_cat;
  logic [W-1:0]    acc_d;
  logic            step_bad;

  always_comb begin
    b_neg = '0;
    for (int i = 0; i < N_TRITS; i++) begin
      b_neg[2*i+:2] = trit_neg(b[2*i+:2]);
    end
  end

  assign chain[0] = carry_q;

  for (genvar i = 0; i < TRITS_PER_CYCLE; i++) begin : g_stage
    ternary_trit_full_add u_fa (
      .a_i    (a_q[2*i+:2]),
      .b_i    (b_q[2*i+:2]),
      .cin_i  (chain[i]),
      .s_o    (step_sum[2*i+:2]),
      .cout_o (chain[i+1]),
      .bad_o  (step_bad_v[i])
    );
  end

  // New digits enter at the top so the first-resolved trit lands at bit 0.
  assign acc_cat  = {step_sum, acc_q};
  assign acc_d    = acc_cat[W+SW-1:SW];
  assign step_bad = |step_bad_v;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign illegal   = illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      carry_q     <= T_ZERO;
      carry_out_q <= T_ZERO;
      bad_q       <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q     <= a;
            b_q     <= op ? b_neg : b;
            acc_q   <= '0;
            carry_q <= T_ZERO;
            bad_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> SW;
          b_q     <= b_q >> SW;
          acc_q   <= acc_d;
          carry_q <= chain[TRITS_PER_CYCLE];
          bad_q   <= bad_q | step_bad;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            sum_q       <= acc_d;
            carry_out_q <= chain[TRITS_PER_CYCLE];
            illegal_q   <= bad_q | step_bad;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_serial_addsub.sv
// Scoreboard bench: three instances (2, 1 and 8 trits per cycle) share the
// input side and are checked against an integer balanced-ternary model.
module tb_ternary_serial_addsub;

  localparam int N = 8;
  localparam int W = 2 * N;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [W-1:0] a_i, b_i;
  logic op_i;
  logic out_ready;

  logic [ND-1:0] in_ready_w;
  logic [ND-1:0] ov;
  logic [W-1:0]  sum_w [ND];
  logic [1:0]    carry_w [ND];
  logic [ND-1:0] ill_w;

  logic [W+2:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int lat_exp[ND] = '{4, 8, 1};

  always #5 clk = ~clk;

  ternary_serial_addsub #(.N_TRITS(N), .TRITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a(a_i), .b(b_i), .op(op_i), .out_valid(ov[0]), .out_ready(out_ready),
    .sum(sum_w[0]), .carry_out(carry_w[0]), .illegal(ill_w[0]));

  ternary_serial_addsub #(.N_TRITS(N), .TRITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a(a_i), .b(b_i), .op(op_i), .out_valid(ov[1]), .out_ready(out_ready),
    .sum(sum_w[1]), .carry_out(carry_w[1]), .illegal(ill_w[1]));

  ternary_serial_addsub #(.N_TRITS(N), .TRITS_PER_CYCLE(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .a(a_i), .b(b_i), .op(op_i), .out_valid(ov[2]), .out_ready(out_ready),
    .sum(sum_w[2]), .carry_out(carry_w[2]), .illegal(ill_w[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {illegal, carry[1:0], sum[W-1:0]} computed with integer arithmetic.
  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mop);
    int va = 0;
    int vb = 0;
    int p = 1;
    int v, r, d;
    logic bad = 1'b0;
    logic [W-1:0] s = '0;
    logic [1:0] c;
    for (int i = 0; i < N; i++) begin
      case (ma[2*i+:2])
        2'b01: va += p;
        2'b10: va -= p;
        2'b11: bad = 1'b1;
        default: ;
      endcase
      case (mb[2*i+:2])
        2'b01: vb += p;
        2'b10: vb -= p;
        2'b11: bad = 1'b1;
        default: ;
      endcase
      p *= 3;
    end
    v = mop ? (va - vb) : (va + vb);
    for (int i = 0; i < N; i++) begin
      r = ((v % 3) + 3) % 3;
      d = (r == 2) ? -1 : r;
      s[2*i+:2] = (d == 1) ? 2'b01 : ((d == -1) ? 2'b10 : 2'b00);
      v = (v - d) / 3;
    end
    c = (v == 1) ? 2'b01 : ((v == -1) ? 2'b10 : 2'b00);
    return {bad, c, s};
  endfunction

  // Called #1 after an edge with all instances idle.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic top,
                       input int hold);
    logic [W+2:0] e;
    int lat[ND];
    int k;
    a_i = ta;
    b_i = tbv;
    op_i = top;
    in_valid = 1'b1;
    check("in_ready_idle", 32'(in_ready_w), 32'(3'b111));
    exp_q.push_back(model(ta, tbv, top));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_i = W'($urandom);
    b_i = W'($urandom);
    op_i = 1'($urandom_range(0, 1));
    out_ready = 1'b1;
    for (int j = 0; j < ND; j++) lat[j] = -1;
    k = 0;
    while (ov != 3'b111 && k < 20) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      k++;
      for (int j = 0; j < ND; j++) if (ov[j] && lat[j] < 0) lat[j] = k;
    end
    for (int j = 0; j < ND; j++) check($sformatf("latency%0d", j), 32'(lat[j]), 32'(lat_exp[j]));
    e = exp_q.pop_front();
    for (int h = 0; h <= hold; h++) begin
      for (int j = 0; j < ND; j++) begin
        check($sformatf("sum%0d", j), 32'(sum_w[j]), 32'(e[W-1:0]));
        check($sformatf("carry%0d", j), 32'(carry_w[j]), 32'(e[W+1:W]));
        check($sformatf("illegal%0d", j), 32'(ill_w[j]), 32'(e[W+2]));
      end
      check("out_valid_hold", 32'(ov), 32'(3'b111));
      check("in_ready_busy", 32'(in_ready_w), 32'(3'b000));
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", 32'(ov), 32'(3'b000));
    check("in_ready_back", 32'(in_ready_w), 32'(3'b111));
  endtask

  task automatic reset_mid_run(input logic [W-1:0] ta, input logic [W-1:0] tbv);
    a_i = ta;
    b_i = tbv;
    op_i = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", 32'(ov), 32'(3'b000));
    check("rst_in_ready", 32'(in_ready_w), 32'(3'b000));
    for (int j = 0; j < ND; j++) begin
      check($sformatf("rst_sum%0d", j), 32'(sum_w[j]), 32'h0);
      check($sformatf("rst_carry%0d", j), 32'(carry_w[j]), 32'h0);
      check($sformatf("rst_illegal%0d", j), 32'(ill_w[j]), 32'h0);
    end
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(in_ready_w), 32'(3'b111));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_i = '0;
    b_i = '0;
    op_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(ov), 32'(3'b000));
    check("reset_in_ready", 32'(in_ready_w), 32'(3'b000));
    for (int j = 0; j < ND; j++) begin
      check($sformatf("reset_sum%0d", j), 32'(sum_w[j]), 32'h0);
      check($sformatf("reset_carry%0d", j), 32'(carry_w[j]), 32'h0);
      check($sformatf("reset_illegal%0d", j), 32'(ill_w[j]), 32'h0);
    end
    rst = 1'b0;
    #1;
    check("reset_release_ready", 32'(in_ready_w), 32'(3'b111));

    do_op(16'h0001, 16'h0001, 1'b0, 0);
    check("basic_add_const", 32'(sum_w[0]), 32'h0006);
    do_op(16'h5555, 16'h0001, 1'b0, 0);
    check("overflow_carry_const", 32'(carry_w[0]), 32'h1);
    do_op(16'h0000, 16'h0001, 1'b1, 0);
    check("subtract_const", 32'(sum_w[0]), 32'h0002);
    do_op(16'h0003, 16'h0001, 1'b0, 0);
    check("illegal_const", 32'(ill_w[0]), 32'h1);
    do_op(16'h0001, 16'h0002, 1'b0, 0);
    do_op(16'hAAAA, 16'h5555, 1'b1, 5);
    do_op(16'hAAAA, 16'hAAAA, 1'b0, 0);

    reset_mid_run(16'h5555, 16'h5555);
    do_op(16'h1234, 16'h0A05, 1'b1, 0);

    for (int n = 0; n < 10; n++) begin
      do_op(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    reset_mid_run(16'h0009, 16'h0006);
    do_op(16'h0009, 16'h0006, 1'b1, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
